// File: rtl/quad_debounce_pkg.sv
// quad_debounce_pkg
// Shared constants and helpers for the rotary-encoder front end.
// Holds the default debounce parameters and a width helper that the
// encoder and PWM stages also use for their counters.
package quad_debounce_pkg;

  localparam int DEF_CHANNELS     = 2;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_PRESCALE     = 250;
  localparam int DEF_STABLE_TICKS = 4;

  // Bits needed to count 0..value-1. Never returns less than 1, so a
  // modulus of 1 still gets a real (constant-zero) register.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One input channel: a synchroniser chain followed by a stability filter
// that is advanced only on sample ticks.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   tick      one-cycle sample strobe shared by all channels
//   in_raw    asynchronous raw pin level
//   out_clean debounced level
//   rise      one-cycle pulse in the cycle out_clean becomes 1
//   fall      one-cycle pulse in the cycle out_clean becomes 0
module debounce_channel
  import quad_debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic in_raw,
  output logic out_clean,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W    = clog2_min1(STABLE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Plain shift chain; bit 0 is the only flop that can go metastable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
    end
  end

  // cnt holds how many consecutive ticks sync_out has disagreed with
  // out_clean. Any agreeing tick clears it, so a short glitch leaves no
  // residue. Strobes default low and are set only on the changing edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_clean <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (sync_out == out_clean) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          out_clean <= sync_out;
          cnt       <= '0;
          rise      <= sync_out;
          fall      <= ~sync_out;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quad_input_debounce.sv
// quad_input_debounce
// Conditions raw rotary-encoder pins before the quadrature decoder:
// each channel is synchronised and then debounced against a shared
// sample tick, so the decoder sees one clean edge per detent transition.
// Ports:
//   clk        system clock (only clock)
//   rst_n      synchronous active-low reset
//   in_raw     asynchronous raw pin levels, one bit per channel
//   out_clean  debounced levels, feed the decoder a/b inputs
//   rise       one-cycle pulse per channel when out_clean goes 0->1
//   fall       one-cycle pulse per channel when out_clean goes 1->0
//   tick       one-cycle sample strobe, exposed for debug/test
module quad_input_debounce
  import quad_debounce_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in_raw,
  output logic [CHANNELS-1:0] out_clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
);

  localparam int               PRE_W    = clog2_min1(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_next;

  always_comb begin
    pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
  end

  // tick is registered from the next count so it is high in exactly the
  // cycle where pre_cnt == PRESCALE-1, and low while in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= pre_next;
      tick    <= (pre_next == PRE_LAST);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .in_raw    (in_raw[i]),
      .out_clean (out_clean[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

endmodule

// File: tb/tb_quad_input_debounce.sv
// Bench for quad_input_debounce: a main build (PRESCALE=4, STABLE_TICKS=3)
// and a fast build (PRESCALE=1, STABLE_TICKS=1) run side by side from one
// clock and one reset. A sample-window model predicts every output on
// every cycle; directed checks pin hand-derived cycle numbers.
module tb_quad_input_debounce;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] in_m, in_f;
  logic [1:0] oc_m, r_m, f_m, oc_f, r_f, f_f;
  logic       t_m, t_f;

  quad_input_debounce #(
    .CHANNELS(2), .SYNC_STAGES(2), .PRESCALE(4), .STABLE_TICKS(3)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .in_raw(in_m),
    .out_clean(oc_m), .rise(r_m), .fall(f_m), .tick(t_m)
  );

  quad_input_debounce #(
    .CHANNELS(2), .SYNC_STAGES(2), .PRESCALE(1), .STABLE_TICKS(1)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .in_raw(in_f),
    .out_clean(oc_f), .rise(r_f), .fall(f_f), .tick(t_f)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Edges since reset are numbered 1,2,... The synchronised level seen
  // before edge t is the pin sampled at edge t-2. A tick is present
  // before edge t when (t-1) mod P == P-1. On each tick the synchronised
  // level is logged; a channel switches when its last ST logged samples
  // all differ from the current clean level.
  localparam int MAXE = 1024;
  localparam int SS   = 2;
  int pre_p [2] = '{4, 1};
  int stk_p [2] = '{3, 1};

  int         en = 0;
  int         nt [2];
  logic [1:0] in_log [2][MAXE];
  logic [1:0] tlog   [2][MAXE];
  logic [1:0] e_clean [2];
  logic [1:0] e_rise  [2];
  logic [1:0] e_fall  [2];
  logic       e_tick  [2];
  bit         mvalid = 0;

  task automatic model_edge(input int k, input logic [1:0] inv);
    logic [1:0] so;
    bit         tick_before;
    bit         all_diff;
    tick_before = (en - 1 >= 1) && (((en - 1) % pre_p[k]) == pre_p[k] - 1);
    so = (en - SS >= 1) ? in_log[k][en-SS] : 2'b00;
    e_rise[k] = 2'b00;
    e_fall[k] = 2'b00;
    if (tick_before) begin
      tlog[k][nt[k]] = so;
      nt[k]++;
      for (int ch = 0; ch < 2; ch++) begin
        if (nt[k] >= stk_p[k]) begin
          all_diff = 1;
          for (int j = 1; j <= stk_p[k]; j++)
            if (tlog[k][nt[k]-j][ch] == e_clean[k][ch]) all_diff = 0;
          if (all_diff) begin
            e_clean[k][ch] = so[ch];
            if (so[ch]) e_rise[k][ch] = 1'b1;
            else        e_fall[k][ch] = 1'b1;
          end
        end
      end
    end
    in_log[k][en] = inv;
    e_tick[k] = ((en % pre_p[k]) == pre_p[k] - 1);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      en     = 0;
      mvalid = 1;
      for (int k = 0; k < 2; k++) begin
        nt[k]      = 0;
        e_clean[k] = 2'b00;
        e_rise[k]  = 2'b00;
        e_fall[k]  = 2'b00;
        e_tick[k]  = 1'b0;
      end
    end else if (en < MAXE - 1) begin
      en = en + 1;
      model_edge(0, in_m);
      model_edge(1, in_f);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_clean", oc_m, e_clean[0]);
      chk("m_rise",  r_m,  e_rise[0]);
      chk("m_fall",  f_m,  e_fall[0]);
      chk("m_tick",  t_m,  e_tick[0]);
      chk("f_clean", oc_f, e_clean[1]);
      chk("f_rise",  r_f,  e_rise[1]);
      chk("f_fall",  f_f,  e_fall[1]);
      chk("f_tick",  t_f,  e_tick[1]);
      chk("m_rise_fall_excl", r_m & f_m, 2'b00);
    end
  end

  // ---------------- driver tasks ----------------
  // Park at the falling edge that follows edge number n since reset.
  task automatic at(input int n);
    int guard;
    guard = 0;
    while (en != n && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (en != n) chk("at_timeout", en, n);
  endtask

  // Fast build: one-cycle in, three-cycle latency out.
  initial begin
    in_f = 2'b00;
    at(2);  in_f = 2'b01;
    at(4);  chk("f_lat_before", oc_f, 2'b00);
    at(5);  chk("f_lat_clean", oc_f, 2'b01); chk("f_lat_rise", r_f, 2'b01);
    at(6);  in_f = 2'b00;
    at(9);  chk("f_fall_clean", oc_f, 2'b00); chk("f_fall_pulse", f_f, 2'b01);
    at(10); in_f = 2'b10;
    at(11); in_f = 2'b00;
    at(13); chk("f_pulse_hi", oc_f, 2'b10); chk("f_pulse_rise", r_f, 2'b10);
    at(14); chk("f_pulse_lo", oc_f, 2'b00); chk("f_pulse_fall", f_f, 2'b10);
    at(16); in_f = 2'b11;
    at(20); in_f = 2'b01;
    at(22); in_f = 2'b00;
  end

  // Main build scenario sequence.
  initial begin
    rst_n = 1'b0;
    in_m  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_clean", oc_m, 2'b00);
      chk("rst_tick",  t_m,  1'b0);
      chk("rst_rise",  r_m | f_m, 2'b00);
    end
    rst_n = 1'b1;
    in_m  = 2'b00;

    at(1);  chk("tick_1", t_m, 1'b0);
    at(3);  chk("tick_3", t_m, 1'b1);
    at(4);  chk("tick_4", t_m, 1'b0);
    at(5);  in_m = 2'b01;
    at(7);  chk("tick_7", t_m, 1'b1);

    at(15); chk("step_before", oc_m, 2'b00);
    at(16); chk("step_clean", oc_m, 2'b01);
            chk("step_rise", r_m, 2'b01);
            chk("step_fall", f_m, 2'b00);
    at(17); chk("step_rise_end", r_m, 2'b00);

    // ch1 glitch: 8 cycles high covers only two evaluating ticks.
    at(20); in_m = 2'b11;
    at(28); in_m = 2'b01;
    at(33); chk("glitch_reject", oc_m, 2'b01);
            in_m = 2'b11;
    // A fresh step must still need three full ticks (edges 36,40,44).
    at(40); chk("glitch_cnt_cleared", oc_m, 2'b01);
    at(43); chk("ch1_before", oc_m, 2'b01);
    at(44); chk("ch1_clean", oc_m, 2'b11);
            chk("ch1_rise", r_m, 2'b10);

    // Both channels fall, then rise, together.
    at(48); in_m = 2'b00;
    at(59); chk("both_fall_before", oc_m, 2'b11);
    at(60); chk("both_fall_clean", oc_m, 2'b00);
            chk("both_fall_pulse", f_m, 2'b11);
            chk("both_fall_norise", r_m, 2'b00);
    at(64); in_m = 2'b11;
    at(75); chk("both_rise_before", oc_m, 2'b00);
    at(76); chk("both_rise_clean", oc_m, 2'b11);
            chk("both_rise_pulse", r_m, 2'b11);
    at(77); chk("both_rise_end", r_m, 2'b00);

    // Reset mid-count: ch0 has two counted ticks when reset hits.
    at(80); in_m = 2'b10;
    at(92); chk("ch0_fall_clean", oc_m, 2'b10);
            chk("ch0_fall_pulse", f_m, 2'b01);
    at(96); in_m = 2'b11;
    at(105);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_clean", oc_m, 2'b00);
    chk("midrst_strobes", r_m | f_m, 2'b00);
    rst_n = 1'b1;
    at(1);  chk("post_rst_strobes", r_m | f_m, 2'b00);
    at(11); chk("post_rst_before", oc_m, 2'b00);
    at(12); chk("post_rst_clean", oc_m, 2'b11);
            chk("post_rst_rise", r_m, 2'b11);
    at(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
